// File: rtl/eae_sequencer.sv
// eae_sequencer: sequences EAE shift, normalize, multiply and divide operations.
// Define EAE_TIMEOUT_EN to abandon a multiply/divide after 64 cycles without a finish strobe.
module eae_sequencer (
    input  logic        clock,
    input  logic        resetN,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [4:0]  shift_cnt,
    input  logic [11:0] ac_in,
    input  logic [11:0] mq_in,
    input  logic        link_in,
    output logic        op_ready,
    output logic        eae_start,
    input  logic        mul_fin,
    input  logic        div_fin,
    input  logic [11:0] unit_ac,
    input  logic [11:0] unit_mq,
    input  logic        unit_link,
    output logic [11:0] ac_out,
    output logic [11:0] mq_out,
    output logic        link_out,
    output logic [4:0]  sc_out,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, SHIFT, NORM, WAIT_UNIT, CAPTURE, DONE} state_t;
    localparam logic [2:0] OP_MUY = 3'd0, OP_DVI = 3'd1, OP_NMI = 3'd2, OP_SHL = 3'd3, OP_ASR = 3'd4, OP_LSR = 3'd5;
    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [11:0] ac_q, ac_d, mq_q, mq_d;
    logic        link_q, link_d, err_q, err_d, start_q, start_d;
    logic [4:0]  cnt_q, cnt_d, sc_q, sc_d;
    logic        fin, timeout, fill;
`ifdef EAE_TIMEOUT_EN
    logic [5:0]  tmo_q, tmo_d;
    assign timeout = tmo_q == 6'd63;
    always_comb tmo_d = state_q == WAIT_UNIT ? tmo_q + 6'd1 : 6'd0;
    always_ff @(posedge clock or negedge resetN)
        if (!resetN) tmo_q <= 6'd0;
        else tmo_q <= tmo_d;
`else
    assign timeout = 1'b0;
`endif
    assign fin  = op_q == OP_MUY ? mul_fin : div_fin;
    assign fill = op_q == OP_ASR && ac_q[11];
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ac_d    = ac_q;
        mq_d    = mq_q;
        link_d  = link_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        sc_d    = sc_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: if (op_valid) begin
                op_d   = op_code;
                ac_d   = ac_in;
                mq_d   = mq_in;
                link_d = link_in;
                cnt_d  = shift_cnt;
                sc_d   = 5'd0;
                err_d  = 1'b0;
                if (op_code == OP_MUY || op_code == OP_DVI) begin
                    state_d = WAIT_UNIT;
                    start_d = 1'b1;
                end else if (op_code == OP_NMI) state_d = NORM;
                else if (op_code <= OP_LSR) state_d = SHIFT;
                else begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            SHIFT: begin
                if (op_q == OP_SHL) {link_d, ac_d, mq_d} = {ac_q, mq_q, 1'b0};
                else {link_d, ac_d, mq_d} = {fill, fill, ac_q, mq_q[11:1]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = DONE;
            end
            // Stop once the top two bits differ, the operand is zero, or 23 shifts are done.
            NORM: if (ac_q[11] == ac_q[10] && {ac_q, mq_q} != 24'd0 && sc_q != 5'd23) begin
                {ac_d, mq_d} = {ac_q[10:0], mq_q, 1'b0};
                sc_d = sc_q + 5'd1;
            end else state_d = DONE;
            WAIT_UNIT: if (fin) state_d = CAPTURE;
            else if (timeout) begin
                state_d = DONE;
                err_d   = 1'b1;
            end
            CAPTURE: begin
                ac_d    = unit_ac;
                mq_d    = unit_mq;
                link_d  = op_q == OP_DVI ? unit_link : link_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge resetN)
        if (!resetN) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            ac_q    <= 12'd0;
            mq_q    <= 12'd0;
            link_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 5'd0;
            sc_q    <= 5'd0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ac_q    <= ac_d;
            mq_q    <= mq_d;
            link_q  <= link_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
            start_q <= start_d;
        end
    assign op_ready  = state_q == IDLE;
    assign done      = state_q == DONE;
    assign eae_start = start_q;
    assign ac_out    = ac_q;
    assign mq_out    = mq_q;
    assign link_out  = link_q;
    assign sc_out    = sc_q;
    assign err       = err_q;
endmodule

// File: tb/tb_eae_sequencer.sv
// tb_eae_sequencer: directed scoreboard bench for eae_sequencer.
module tb_eae_sequencer;
    logic        clock = 1'b0;
    logic        resetN, op_valid, link_in, mul_fin, div_fin, unit_link;
    logic [2:0]  op_code;
    logic [4:0]  shift_cnt, sc_out;
    logic [11:0] ac_in, mq_in, unit_ac, unit_mq, ac_out, mq_out;
    logic        op_ready, eae_start, link_out, done, err;

    typedef struct packed {
        logic [11:0] ac;
        logic [11:0] mq;
        logic        link;
        logic [4:0]  sc;
        logic        err;
    } res_t;

    res_t exp_q[$];
    int checks = 0;
    int errors = 0;

    eae_sequencer dut (
        .clock(clock), .resetN(resetN), .op_valid(op_valid), .op_code(op_code),
        .shift_cnt(shift_cnt), .ac_in(ac_in), .mq_in(mq_in), .link_in(link_in),
        .op_ready(op_ready), .eae_start(eae_start), .mul_fin(mul_fin), .div_fin(div_fin),
        .unit_ac(unit_ac), .unit_mq(unit_mq), .unit_link(unit_link),
        .ac_out(ac_out), .mq_out(mq_out), .link_out(link_out), .sc_out(sc_out),
        .done(done), .err(err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic res_t mk(input logic [11:0] a, input logic [11:0] m, input logic l,
                                input logic [4:0] s, input logic e);
        res_t r;
        r.ac = a; r.mq = m; r.link = l; r.sc = s; r.err = e;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input logic [2:0] code, input logic [4:0] cnt, input logic [11:0] a,
                         input logic [11:0] m, input logic l, input bit push, input res_t e);
        @(negedge clock);
        op_valid = 1'b1; op_code = code; shift_cnt = cnt; ac_in = a; mq_in = m; link_in = l;
        if (push) exp_q.push_back(e);
        @(negedge clock);
        op_valid = 1'b0;
    endtask

    // Starts at the negedge following the accepting edge; lat counts further edges until done.
    task automatic finish_op(input string tag, input int lat);
        int n;
        res_t e;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        op_valid = 1'b0;
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_sb"}, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_ac"}, ac_out, e.ac);
            chk({tag, "_mq"}, mq_out, e.mq);
            chk({tag, "_link"}, link_out, e.link);
            chk({tag, "_sc"}, sc_out, e.sc);
            chk({tag, "_err"}, err, e.err);
        end
        @(negedge clock);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_ready"}, op_ready, 1);
    endtask

    initial begin
        int starts;
        int dones;
        resetN = 1'b0; op_valid = 1'b0; op_code = 3'd0; shift_cnt = 5'd0;
        ac_in = 12'd0; mq_in = 12'd0; link_in = 1'b0;
        mul_fin = 1'b0; div_fin = 1'b0; unit_ac = 12'd0; unit_mq = 12'd0; unit_link = 1'b0;
        #1;
        chk("rst_ready", op_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_start", eae_start, 0);
        chk("rst_ac", ac_out, 0);
        chk("rst_err", err, 0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;

        issue(3'd3, 5'd2, 12'o7001, 12'o0000, 1'b0, 1, mk(12'o0010, 12'o0000, 1'b1, 5'd0, 1'b0));
        finish_op("shl", 3);
        issue(3'd4, 5'd0, 12'o4000, 12'o0000, 1'b0, 1, mk(12'o6000, 12'o0000, 1'b1, 5'd0, 1'b0));
        finish_op("asr", 1);
        issue(3'd5, 5'd11, 12'o4000, 12'o0001, 1'b1, 1, mk(12'o0000, 12'o4000, 1'b0, 5'd0, 1'b0));
        finish_op("lsr", 12);
        issue(3'd2, 5'd0, 12'o0001, 12'o0000, 1'b0, 1, mk(12'o2000, 12'o0000, 1'b0, 5'd10, 1'b0));
        finish_op("nmi", 11);
        issue(3'd2, 5'd0, 12'o0000, 12'o0000, 1'b0, 1, mk(12'o0000, 12'o0000, 1'b0, 5'd0, 1'b0));
        finish_op("nmi_zero", 1);
        issue(3'd2, 5'd0, 12'o7777, 12'o7777, 1'b0, 1, mk(12'o4000, 12'o0000, 1'b0, 5'd23, 1'b0));
        finish_op("nmi_cap", 24);
        issue(3'd7, 5'd0, 12'o1111, 12'o2222, 1'b1, 1, mk(12'o1111, 12'o2222, 1'b1, 5'd0, 1'b1));
        finish_op("illegal", 0);

        // MUY: stub finishes 12 cycles after the launch pulse; a stray div_fin must be ignored.
        issue(3'd0, 5'd0, 12'o0006, 12'o0011, 1'b0, 1, mk(12'o0000, 12'o0062, 1'b0, 5'd0, 1'b0));
        chk("muy_start", eae_start, 1);
        starts = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            starts += int'(eae_start);
            div_fin = i == 5;
        end
        chk("muy_busy", op_ready, 0);
        chk("muy_no_early_done", done, 0);
        mul_fin = 1'b1; unit_ac = 12'o0000; unit_mq = 12'o0062; unit_link = 1'b1;
        @(negedge clock);
        mul_fin = 1'b0;
        finish_op("muy", 1);
        chk("muy_extra_starts", starts, 0);

        // DVI: a stray mul_fin must be ignored; unit_link is captured.
        issue(3'd1, 5'd0, 12'o1234, 12'o5670, 1'b0, 1, mk(12'o0017, 12'o0444, 1'b1, 5'd0, 1'b0));
        chk("dvi_start", eae_start, 1);
        mul_fin = 1'b1;
        @(negedge clock);
        mul_fin = 1'b0;
        @(negedge clock);
        chk("dvi_ignore_mul_fin", done, 0);
        chk("dvi_busy", op_ready, 0);
        div_fin = 1'b1; unit_ac = 12'o0017; unit_mq = 12'o0444; unit_link = 1'b1;
        @(negedge clock);
        div_fin = 1'b0;
        finish_op("dvi", 1);

        // op_valid held through the whole operation; inputs change while busy.
        @(negedge clock);
        op_valid = 1'b1; op_code = 3'd3; shift_cnt = 5'd4; ac_in = 12'o0003; mq_in = 12'o4000; link_in = 1'b0;
        exp_q.push_back(mk(12'o0160, 12'o0000, 1'b0, 5'd0, 1'b0));
        @(negedge clock);
        ac_in = 12'o7777; mq_in = 12'o0000;
        finish_op("shl_hold", 5);
        @(negedge clock);
        chk("hold_single_accept", op_ready, 1);

`ifdef EAE_TIMEOUT_EN
        issue(3'd1, 5'd0, 12'o0123, 12'o0456, 1'b1, 1, mk(12'o0123, 12'o0456, 1'b1, 5'd0, 1'b1));
        finish_op("dvi_timeout", 64);
`endif

        // Reset while waiting for a unit that never finishes.
        issue(3'd1, 5'd0, 12'o0321, 12'o0654, 1'b1, 0, mk(12'o0, 12'o0, 1'b0, 5'd0, 1'b0));
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            dones += int'(done);
        end
        chk("abort_no_done_wait", dones, 0);
        chk("abort_busy", op_ready, 0);
        #2 resetN = 1'b0;
        #1;
        chk("abort_ready", op_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_start", eae_start, 0);
        chk("abort_ac", ac_out, 0);
        chk("abort_link", link_out, 0);
        @(negedge clock);
        resetN = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            dones += int'(done);
        end
        chk("abort_no_done_after", dones, 0);
        chk("abort_idle", op_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eae_sequencer.md
EAE_SEQUENCER -- requirements
Module: eae_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  system clock (rising edge).
REQ-002 SHALL have: resetN  in  1  asynchronous active-low reset.
REQ-003 SHALL have: op_valid  in  1  operation request.
REQ-004 SHALL have: op_code  in  3  operation code: 0=MUY, 1=DVI, 2=NMI, 3=SHL, 4=ASR, 5=LSR, 6-7=illegal.
REQ-005 SHALL have: shift_cnt  in  5  shift count; SHL/ASR/LSR perform shift_cnt+1 bit shifts.
REQ-006 SHALL have: ac_in, mq_in  in  12 each  operand registers; link_in  in  1.
REQ-007 SHALL have: op_ready  out  1  high only in IDLE.
REQ-008 SHALL have: eae_start  out  1  one-cycle launch pulse to the multiply/divide units.
REQ-009 SHALL have: mul_fin, div_fin  in  1 each  unit finished strobes.
REQ-010 SHALL have: unit_ac, unit_mq  in  12 each; unit_link  in  1  registered unit results.
REQ-011 SHALL have: ac_out, mq_out  out  12 each; link_out  out  1; sc_out  out  5  normalize shift count.
REQ-012 SHALL have: done  out  1  one-cycle completion pulse; err  out  1  error flag, valid with done.

Function
REQ-013 SHALL implement states IDLE, SHIFT, NORM, WAIT_UNIT, CAPTURE, DONE.
REQ-014 SHALL accept an op on a rising edge with op_valid=1 in IDLE: latch op_code, ac_in, mq_in, link_in, shift_cnt; clear err and sc_out; op_valid outside IDLE is ignored.
REQ-015 SHALL, for SHL/ASR/LSR, go IDLE->SHIFT and perform one bit per cycle on {link,ac,mq}; after N=shift_cnt+1 shift edges, go to DONE.
REQ-016 SHALL, for SHL: shift left, zero into mq[0], link takes the bit shifted out of ac[11].
REQ-017 SHALL, for ASR: shift {ac,mq} right, ac[11] replicated, link = ac[11]; for LSR: zero into ac[11], link cleared.
REQ-018 SHALL, for NMI: shift {ac,mq} left one bit per cycle while ac[11]==ac[10] and {ac,mq}!=0, incrementing sc_out; cap at 23 shifts; zero operand completes with sc_out=0.
REQ-019 SHALL, for MUY/DVI: assert eae_start for exactly the accepting cycle+1, enter WAIT_UNIT, wait for mul_fin (MUY) or div_fin (DVI).
REQ-020 SHALL, on the relevant fin strobe, enter CAPTURE, then load unit_ac/unit_mq into ac_out/mq_out (and unit_link for DVI; link unchanged for MUY) and enter DONE.
REQ-021 SHALL ignore the non-selected fin strobe.
REQ-022 SHALL, for an illegal op_code, go directly to DONE with err=1 and outputs equal to latched inputs.
REQ-023 SHALL assert done for exactly one cycle in DONE and then return to IDLE; ac_out/mq_out/link_out/sc_out/err hold until the next accept.

Reset
REQ-024 SHALL, on resetN low (any time, including mid-operation), go to IDLE immediately; all outputs 0 except op_ready=1 once in IDLE; no eae_start or done issued.

Configuration
REQ-025 SHALL support macro EAE_TIMEOUT_EN: when defined, a 6-bit counter runs in WAIT_UNIT; after 64 cycles without the selected fin strobe, go to DONE with err=1 and ac/mq/link unchanged from inputs.
REQ-026 SHALL, without EAE_TIMEOUT_EN, wait indefinitely in WAIT_UNIT; err is then set only by illegal op_code.

Verification
REQ-027 SHL ac=0o7001 mq=0 link=0 shift_cnt=2 -> done 3 edges after accept, ac_out=0o0010, mq_out=0, link_out=1.
REQ-028 ASR ac=0o4000 mq=0 shift_cnt=0 -> ac_out=0o6000, link_out=1; LSR ac=0o4000 mq=0o0001 shift_cnt=11 -> ac_out=0, mq_out=0o4000, link_out=0.
REQ-029 NMI ac=0o0001 mq=0 -> ac_out=0o2000, sc_out=10; NMI of zero -> sc_out=0, done after 1 edge.
REQ-030 MUY with stub raising mul_fin 12 cycles after eae_start, unit_ac=0, unit_mq=0o0062 -> single eae_start pulse, done 2 cycles after mul_fin, mq_out=0o0062; spurious div_fin ignored.
REQ-031 DVI with stub never finishing, EAE_TIMEOUT_EN defined -> done with err=1 after 64 WAIT_UNIT cycles; resetN pulsed mid-WAIT_UNIT -> IDLE, op_ready=1, no done.
REQ-032 op_code=7 -> done next cycle, err=1; op_valid held high during busy -> exactly one operation accepted.
